key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 4, giving the number of push-button inputs conditioned.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), giving the number of consecutive stable synchronised samples required to accept a level change; legal range 1 to 2^CNT_W-1.
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 0, giving the hold time in cycles before auto-repeat starts; 0 disables auto-repeat.
REQ-004 The block SHALL have parameter REPEAT_PERIOD, default 5000000, giving the auto-repeat interval in cycles; legal range 1 to 2^CNT_W-1.
REQ-005 The block SHALL have parameter CNT_W, default 24, giving the width of every per-key counter.
REQ-006 CLOCK_50  input  1  sole clock; all flops SHALL be clocked on its rising edge.
REQ-007 RESET_N  input  1  synchronous, active-low reset.
REQ-008 KEY  input  N_KEYS  raw asynchronous buttons, active-low (0 = pressed).
REQ-009 DOWN  output  N_KEYS  registered debounced level, active-high (1 = held).
REQ-010 PRESS  output  N_KEYS  registered one-cycle pulse on accepted press and on each auto-repeat.
REQ-011 RELEASE  output  N_KEYS  registered one-cycle pulse on accepted release.

Function
REQ-012 Each KEY bit SHALL pass through a 2-flop synchroniser before any other logic uses it; no other logic SHALL sample KEY directly.
REQ-013 Each key SHALL hold an internal debounced active-low state, db_n, and a debounce counter, dcnt.
REQ-014 When sync output equals db_n, dcnt SHALL clear to 0 on that edge.
REQ-015 When sync output differs from db_n and dcnt < DEBOUNCE_CYCLES-1, dcnt SHALL increment.
REQ-016 When sync output differs from db_n and dcnt == DEBOUNCE_CYCLES-1, db_n SHALL take the sync value and dcnt SHALL clear.
REQ-017 Latency: KEY first sampled stable at edge k and held SHALL update DOWN at edge k+DEBOUNCE_CYCLES+1; any intervening bounce SHALL restart the count.
REQ-018 DOWN[i] SHALL equal ~db_n[i].
REQ-019 On the edge where db_n goes 1->0, PRESS[i] SHALL be set for exactly one cycle, coincident with DOWN[i] rising.
REQ-020 On the edge where db_n goes 0->1, RELEASE[i] SHALL be set for exactly one cycle, coincident with DOWN[i] falling.
REQ-021 Auto-repeat: with REPEAT_DELAY>0 and a press accepted in cycle P, while DOWN[i] stays 1, PRESS[i] SHALL also pulse in cycles P+REPEAT_DELAY+n*REPEAT_PERIOD, n = 0,1,2,...
REQ-022 The per-key repeat counter SHALL clear in the press cycle and on DOWN falling.
REQ-023 Repeat pulses SHALL continue during a pending release debounce and SHALL stop in the cycle DOWN falls.
REQ-024 Keys SHALL be fully independent; simultaneous events on several keys SHALL produce pulses on all of them in the same cycle.
REQ-025 Counters SHALL never wrap; they are bounded by DEBOUNCE_CYCLES-1, REPEAT_DELAY and REPEAT_PERIOD.

Reset
REQ-026 On an edge with RESET_N=0: synchronisers SHALL be set to 1, db_n set to 1, all counters set to 0, and DOWN, PRESS and RELEASE set to 0.
REQ-027 Reset SHALL take priority over every event, including a debounce completing in the same cycle.
REQ-028 A key held low across reset release SHALL be reported as a fresh press after the full REQ-017 latency measured from the first non-reset edge.

Verification (bench parameters: N_KEYS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CNT_W=8)
REQ-029 Clean press: KEY[0] low from edge 0 -> DOWN[0]=1 and PRESS[0]=1 after edge 5; PRESS[0]=0 after edge 6; other bits remain 0.
REQ-030 Bounce: KEY[1] low 3 cycles, high 1 cycle, repeated 5 times, then low steady -> no PRESS during bounce; exactly one PRESS[1], 5 cycles after the steady low begins.
REQ-031 Release: KEY[0] returns high at edge 40 -> RELEASE[0]=1 and DOWN[0]=0 after edge 45, for one cycle only.
REQ-032 Repeat: KEY[2] held low for 30 cycles from edge 0 -> PRESS[2] in cycles 5, 15, 18, 21, 24, 27, 30, 33; none after DOWN[2] falls.
REQ-033 Reset mid-count: RESET_N=0 for 1 cycle when dcnt[3]=2 -> all outputs 0 on the next edge; with KEY[3] still low, PRESS[3] follows 5 cycles after reset release.
REQ-034 Simultaneous: KEY[0] and KEY[3] fall in the same cycle -> PRESS[0] and PRESS[3] assert in the same cycle.

Source files
------------

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Conditions a bank of raw, active-low push buttons into clean, active-high
// key events. Each key is handled by its own independent slice:
//   2-flop synchroniser -> stable-run debouncer -> edge pulses -> auto-repeat.
//
// Parameters
//   N_KEYS          number of buttons conditioned
//   DEBOUNCE_CYCLES consecutive stable synchronised samples needed to accept a
//                   level change (1 .. 2^CNT_W-1)
//   REPEAT_DELAY    hold time in cycles before auto-repeat starts (0 = off)
//   REPEAT_PERIOD   auto-repeat interval in cycles (1 .. 2^CNT_W-1)
//   CNT_W           width of every per-key counter
//
// Ports
//   CLOCK_50  in   1       sole clock, rising edge
//   RESET_N   in   1       synchronous reset, active low
//   KEY       in   N_KEYS  raw asynchronous buttons, 0 = pressed
//   DOWN      out  N_KEYS  debounced level, 1 = held
//   PRESS     out  N_KEYS  one-cycle pulse on accepted press and each repeat
//   RELEASE   out  N_KEYS  one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 24
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] DOWN,
  output logic [N_KEYS-1:0] PRESS,
  output logic [N_KEYS-1:0] RELEASE
);

  localparam bit               L_REP_EN  = (REPEAT_DELAY > 0);
  localparam logic [CNT_W-1:0] L_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_RD_LAST = CNT_W'(L_REP_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] L_RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      logic             r_sync1;
      logic             r_sync2;
      logic             r_db_n;      // accepted level, active low
      logic [CNT_W-1:0] r_dcnt;      // length of current run differing from r_db_n
      logic [CNT_W-1:0] r_rcnt;      // cycles since last press / repeat pulse
      logic             r_rep_phase; // 0: waiting out the initial delay, 1: periodic
      logic             r_press;
      logic             r_release;

      logic w_differ;
      logic w_accept;
      logic w_press_evt;
      logic w_release_evt;
      logic w_rep_hit;

      assign w_differ      = (r_sync2 != r_db_n);
      // The sample that makes the run DEBOUNCE_CYCLES long flips the level.
      assign w_accept      = w_differ && (r_dcnt == L_DB_LAST);
      assign w_press_evt   = w_accept && r_db_n;
      assign w_release_evt = w_accept && !r_db_n;
      // Initial delay and period share one counter; the phase bit picks the
      // terminal count.
      assign w_rep_hit     = L_REP_EN && !r_db_n &&
                             (r_rcnt == (r_rep_phase ? L_RP_LAST : L_RD_LAST));

      always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
          r_sync1     <= 1'b1;
          r_sync2     <= 1'b1;
          r_db_n      <= 1'b1;
          r_dcnt      <= '0;
          r_rcnt      <= '0;
          r_rep_phase <= 1'b0;
          r_press     <= 1'b0;
          r_release   <= 1'b0;
        end else begin
          r_sync1 <= KEY[gi];
          r_sync2 <= r_sync1;

          if (!w_differ) begin
            r_dcnt <= '0;
          end else if (w_accept) begin
            r_db_n <= r_sync2;
            r_dcnt <= '0;
          end else begin
            r_dcnt <= r_dcnt + CNT_W'(1);
          end

          r_release <= w_release_evt;

          // A release edge wins over a repeat landing in the same cycle, so
          // repeats stop exactly when DOWN falls.
          if (w_press_evt || w_release_evt || r_db_n) begin
            r_rcnt      <= '0;
            r_rep_phase <= 1'b0;
            r_press     <= w_press_evt;
          end else if (w_rep_hit) begin
            r_rcnt      <= '0;
            r_rep_phase <= 1'b1;
            r_press     <= 1'b1;
          end else begin
            r_rcnt      <= L_REP_EN ? r_rcnt + CNT_W'(1) : '0;
            r_press     <= 1'b0;
          end
        end
      end

      // r_db_n is itself a flop, so DOWN is registered and moves on the same
      // edge as the PRESS/RELEASE pulses.
      assign DOWN[gi]    = !r_db_n;
      assign PRESS[gi]   = r_press;
      assign RELEASE[gi] = r_release;
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk;
  logic         RESET_N;
  logic [N-1:0] KEY;
  logic [N-1:0] DOWN;
  logic [N-1:0] PRESS;
  logic [N-1:0] RELEASE;

  key_conditioner #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(8)
  ) dut (
    .CLOCK_50(clk), .RESET_N(RESET_N), .KEY(KEY),
    .DOWN(DOWN), .PRESS(PRESS), .RELEASE(RELEASE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } ev_t;

  ev_t sb_q[$];

  // ---------------------------------------------------------------------------
  // Reference model: a level change is accepted once the last D synchronised
  // samples all agree and differ from the accepted level. Synchronised sample
  // at edge t is the raw sample from edge t-2 (reset loads released values).
  // Repeats are pure arithmetic on the elapsed time since the press.
  // ---------------------------------------------------------------------------
  int           cyc = -1;
  logic [N-1:0] m_db = '1;
  logic [N-1:0] exp_down = '0;
  logic [N-1:0] raw_q[$];
  logic [N-1:0] vis_q[$];
  int           press_cyc[N];

  always @(posedge clk) begin
    logic [N-1:0] vis;
    logic [N-1:0] ep;
    logic [N-1:0] er;
    bit           stable;
    int           el;
    ev_t          e;
    cyc++;
    if (!RESET_N) begin
      m_db     = '1;
      raw_q    = {};
      raw_q.push_back('1);
      raw_q.push_back('1);
      vis_q    = {};
      exp_down = '0;
    end else begin
      raw_q.push_back(KEY);
      vis = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : '1;
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      vis_q.push_back(vis);
      if (vis_q.size() > D) void'(vis_q.pop_front());
      ep = '0;
      er = '0;
      for (int i = 0; i < N; i++) begin
        if (vis_q.size() == D) begin
          stable = 1'b1;
          for (int j = 1; j < D; j++)
            if (vis_q[j][i] != vis_q[0][i]) stable = 1'b0;
          if (stable && vis_q[0][i] != m_db[i]) begin
            m_db[i] = vis_q[0][i];
            if (!m_db[i]) begin
              ep[i] = 1'b1;
              press_cyc[i] = cyc;
            end else begin
              er[i] = 1'b1;
            end
          end
        end
        if (!m_db[i] && !ep[i]) begin
          el = cyc - press_cyc[i];
          if (el >= RD && ((el - RD) % RP) == 0) ep[i] = 1'b1;
        end
      end
      exp_down = ~m_db;
      if ((ep | er) != '0) begin
        e.cyc   = cyc;
        e.press = ep;
        e.rel   = er;
        sb_q.push_back(e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: checks DOWN every cycle and pops one expected event whenever the
  // DUT presents a PRESS or RELEASE pulse.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    ev_t me;
    if (cyc >= 0) begin
      checks++;
      if (DOWN !== exp_down) begin
        errors++;
        $display("FAIL down cyc %0d got %b expected %b", cyc, DOWN, exp_down);
      end
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        me = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event cyc %0d got none expected press %b release %b",
                 me.cyc, me.press, me.rel);
      end
      if ((PRESS | RELEASE) !== '0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc %0d got press %b release %b expected none",
                   cyc, PRESS, RELEASE);
        end else begin
          me = sb_q.pop_front();
          if (me.cyc != cyc || me.press !== PRESS || me.rel !== RELEASE) begin
            errors++;
            $display("FAIL event cyc %0d got press %b release %b expected cyc %0d press %b release %b",
                     cyc, PRESS, RELEASE, me.cyc, me.press, me.rel);
          end else begin
            $display("cyc %0d event press %b release %b down %b ok", cyc, PRESS, RELEASE, DOWN);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus and directed spot checks (relative edge r of each scenario)
  // ---------------------------------------------------------------------------
  task automatic step(input logic [N-1:0] k, input logic rn);
    KEY     = k;
    RESET_N = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  logic [N-1:0] kv;
  int           hold[N];
  int           first_p;
  int           plist[$];
  int           exp_list[8] = '{5, 15, 18, 21, 24, 27, 30, 33};

  initial begin
    KEY     = '1;
    RESET_N = 1'b0;

    // Reset state
    repeat (3) step('1, 1'b0);
    chk("reset_down", DOWN, '0);
    chk("reset_press", PRESS, '0);
    chk("reset_release", RELEASE, '0);
    repeat (3) step('1, 1'b1);

    // Clean press and release of key 0
    for (int r = 0; r <= 50; r++) begin
      step((r < 40) ? 4'b1110 : 4'b1111, 1'b1);
      if (r == 4)  chk("clean_down_early", DOWN, 4'b0000);
      if (r == 5)  chk("clean_down", DOWN, 4'b0001);
      if (r == 5)  chk("clean_press", PRESS, 4'b0001);
      if (r == 6)  chk("clean_press_end", PRESS, 4'b0000);
      if (r == 42) chk("repeat_in_release_debounce", PRESS, 4'b0001);
      if (r == 44) chk("release_down_early", DOWN, 4'b0001);
      if (r == 45) chk("release_pulse", RELEASE, 4'b0001);
      if (r == 45) chk("release_down", DOWN, 4'b0000);
      if (r == 45) chk("no_repeat_on_fall", PRESS, 4'b0000);
      if (r == 46) chk("release_pulse_end", RELEASE, 4'b0000);
    end
    repeat (4) step('1, 1'b1);

    // Bouncing key 1: five runs of 3 low / 1 high, then steady low
    first_p = -1;
    for (int r = 0; r <= 45; r++) begin
      kv = '1;
      if (r < 20)      kv[1] = ((r % 4) == 3);
      else if (r < 35) kv[1] = 1'b0;
      step(kv, 1'b1);
      if (PRESS[1] && first_p < 0) first_p = r;
    end
    chk_int("bounce_first_press", first_p, 25);
    repeat (4) step('1, 1'b1);

    // Auto-repeat on key 2 held 30 cycles
    plist = {};
    for (int r = 0; r <= 45; r++) begin
      step((r < 30) ? 4'b1011 : 4'b1111, 1'b1);
      if (PRESS[2]) plist.push_back(r);
      if (r == 34) chk("repeat_down_held", DOWN, 4'b0100);
      if (r == 35) chk("repeat_down_fell", DOWN, 4'b0000);
    end
    chk_int("repeat_count", plist.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < plist.size()) chk_int("repeat_cycle", plist[i], exp_list[i]);
    repeat (4) step('1, 1'b1);

    // Reset while key 3 is mid-count, key 0 already held
    for (int r = 0; r <= 40; r++) begin
      kv = '1;
      if (r < 30)             kv[0] = 1'b0;
      if (r >= 10 && r < 30)  kv[3] = 1'b0;
      step(kv, (r == 14) ? 1'b0 : 1'b1);
      if (r == 13) chk("midreset_before", DOWN, 4'b0001);
      if (r == 14) chk("midreset_down", DOWN, 4'b0000);
      if (r == 14) chk("midreset_press", PRESS, 4'b0000);
      if (r == 14) chk("midreset_release", RELEASE, 4'b0000);
      if (r == 19) chk("midreset_down_early", DOWN, 4'b0000);
      if (r == 20) chk("midreset_repress", PRESS, 4'b1001);
    end
    repeat (4) step('1, 1'b1);

    // Reset on the very edge a debounce would complete
    for (int r = 0; r <= 30; r++) begin
      step((r <= 20) ? 4'b1101 : 4'b1111, (r == 5) ? 1'b0 : 1'b1);
      if (r == 5)  chk("rst_prio_down", DOWN, 4'b0000);
      if (r == 5)  chk("rst_prio_press", PRESS, 4'b0000);
      if (r == 10) chk("rst_prio_down_early", DOWN, 4'b0000);
      if (r == 11) chk("rst_prio_repress", PRESS, 4'b0010);
    end
    repeat (4) step('1, 1'b1);

    // Simultaneous press and release on keys 0 and 3
    for (int r = 0; r <= 16; r++) begin
      step((r < 8) ? 4'b0110 : 4'b1111, 1'b1);
      if (r == 5)  chk("simul_press", PRESS, 4'b1001);
      if (r == 6)  chk("simul_press_end", PRESS, 4'b0000);
      if (r == 13) chk("simul_release", RELEASE, 4'b1001);
    end
    repeat (4) step('1, 1'b1);

    // Randomised hold lengths and occasional resets
    kv = '1;
    for (int i = 0; i < N; i++) hold[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          kv[i]   = ~kv[i];
          hold[i] = kv[i] ? $urandom_range(1, 10) : $urandom_range(1, 25);
        end
        hold[i]--;
      end
      step(kv, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end

    repeat (40) step('1, 1'b1);
    chk_int("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
